ysyx_23060201_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC datapath (PC, IFU, IDU, EXU, GPR). It turns the single-cycle core into a handshaked fetch/decode/execute/memory/writeback machine. It drives instruction-fetch and load/store bus requests, and gates PC and GPR updates so that each instruction commits exactly once. It also provides halt detection with a cause code, a bus timeout, and cycle/instret counters for the simulation harness.

---
 rtl/ysyx_23060201_ctrl_pkg.sv | 28 ++
 rtl/ysyx_23060201_wdog.sv | 34 +++
 rtl/ysyx_23060201_ctrl.sv | 155 +++++++++++++++
 tb/tb_ysyx_23060201_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060201_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer and its watchdog.
package ysyx_23060201_ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_FETCH  = 4'd1,
    S_IWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_MWAIT  = 4'd6,
    S_WB     = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [1:0] HC_EBREAK  = 2'd0;
  localparam logic [1:0] HC_FETCH   = 2'd1;
  localparam logic [1:0] HC_LSU     = 2'd2;
  localparam logic [1:0] HC_ILLEGAL = 2'd3;

  localparam int TIMEOUT_DEF = 255;

  // Enough bits to hold the value TIMEOUT itself, so the counter can saturate there.
  function automatic int tmo_width(input int tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/ysyx_23060201_wdog.sv
// Bus watchdog: counts cycles of an outstanding transaction and flags the cycle in
// which the count reaches TIMEOUT. Cleared whenever no transaction is in flight.
module ysyx_23060201_wdog
  import ysyx_23060201_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = tmo_width(TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The increment happening this cycle is the one that reaches TIMEOUT.
  assign expired = inc && (cnt >= LAST);

endmodule

// File: rtl/ysyx_23060201_ctrl.sv
// Multi-cycle sequencer for the NPC core: handshaked fetch/decode/execute/memory/
// writeback, sticky halt with cause, bus watchdog and cycle/instret counters.
module ysyx_23060201_ctrl
  import ysyx_23060201_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_gnt,
  input  logic        ifu_rvalid,
  input  logic        ifu_err,
  output logic        inst_we,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        lsu_req,
  output logic        lsu_we,
  input  logic        lsu_gnt,
  input  logic        lsu_rvalid,
  input  logic        lsu_err,
  output logic        pc_we,
  output logic        gpr_we,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_t     state;
  state_t     state_nx;
  logic [1:0] code_nx;
  logic       store_q;
  logic       in_xfer;
  logic       tmo_exp;
  logic       ifu_resp;
  logic       lsu_resp;

  assign in_xfer = (state == S_FETCH) || (state == S_IWAIT) ||
                   (state == S_MEM)   || (state == S_MWAIT);

  // A response only counts once the request has been granted.
  assign ifu_resp = ((state == S_FETCH) && ifu_gnt && ifu_rvalid) ||
                    ((state == S_IWAIT) && ifu_rvalid);
  assign lsu_resp = ((state == S_MEM) && lsu_gnt && lsu_rvalid) ||
                    ((state == S_MWAIT) && lsu_rvalid);

  ysyx_23060201_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (~in_xfer),
    .inc     (in_xfer),
    .expired (tmo_exp)
  );

  always_comb begin
    state_nx = state;
    code_nx  = HC_EBREAK;
    case (state)
      S_BOOT: state_nx = S_FETCH;
      S_FETCH, S_IWAIT: begin
        if (ifu_resp) begin
          if (ifu_err) begin
            state_nx = S_HALT;
            code_nx  = HC_FETCH;
          end else begin
            state_nx = S_DECODE;
          end
        end else if (tmo_exp) begin
          state_nx = S_HALT;
          code_nx  = HC_FETCH;
        end else if ((state == S_FETCH) && ifu_gnt) begin
          state_nx = S_IWAIT;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_nx = S_HALT;
          code_nx  = HC_ILLEGAL;
        end else if (dec_ebreak) begin
          state_nx = S_HALT;
          code_nx  = HC_EBREAK;
        end else if (dec_load || dec_store) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: state_nx = S_FETCH;
      S_MEM, S_MWAIT: begin
        if (lsu_resp) begin
          if (lsu_err) begin
            state_nx = S_HALT;
            code_nx  = HC_LSU;
          end else begin
            state_nx = S_WB;
          end
        end else if (tmo_exp) begin
          state_nx = S_HALT;
          code_nx  = HC_LSU;
        end else if ((state == S_MEM) && lsu_gnt) begin
          state_nx = S_MWAIT;
        end
      end
      S_WB:   state_nx = S_FETCH;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BOOT;
      halt_code <= HC_EBREAK;
      store_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state != S_HALT) && (state_nx == S_HALT)) begin
        halt_code <= code_nx;
      end
      if (state == S_DECODE) begin
        store_q <= dec_store;
      end
    end
  end

  // inst_we must coincide with the bus beat carrying the instruction.
  assign inst_we = ifu_resp && !ifu_err;

  assign ifu_req = (state == S_FETCH);
  assign lsu_req = (state == S_MEM);
  assign lsu_we  = (state == S_MEM) && store_q;
  assign pc_we   = (state == S_EXEC) || (state == S_WB);
  assign gpr_we  = (state == S_EXEC) || ((state == S_WB) && !store_q);
  assign halt    = (state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state != S_BOOT) && (state != S_HALT)) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (pc_we) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_ctrl.sv
// Self-checking bench for the NPC sequencer: randomized bus latencies and noise,
// expectations derived per instruction from phase lengths and outcome rules.
module tb_ysyx_23060201_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req, ifu_gnt, ifu_rvalid, ifu_err, inst_we;
  logic        dec_load, dec_store, dec_ebreak, dec_illegal;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
  logic        pc_we, gpr_we, halt;
  logic [1:0]  halt_code;
  logic [31:0] cycle_cnt, instret_cnt;

  ysyx_23060201_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_req     (ifu_req),
    .ifu_gnt     (ifu_gnt),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_err     (ifu_err),
    .inst_we     (inst_we),
    .dec_load    (dec_load),
    .dec_store   (dec_store),
    .dec_ebreak  (dec_ebreak),
    .dec_illegal (dec_illegal),
    .lsu_req     (lsu_req),
    .lsu_we      (lsu_we),
    .lsu_gnt     (lsu_gnt),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_err     (lsu_err),
    .pc_we       (pc_we),
    .gpr_we      (gpr_we),
    .halt        (halt),
    .halt_code   (halt_code),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cycle;
  logic [31:0] exp_instret;

  task automatic idle_inputs();
    ifu_gnt = 0; ifu_rvalid = 0; ifu_err = 0;
    lsu_gnt = 0; lsu_rvalid = 0; lsu_err = 0;
    dec_load = 0; dec_store = 0; dec_ebreak = 0; dec_illegal = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    exp_cycle = 0;
    exp_instret = 0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 ebreak, 4 illegal.
  // g/gm: cycles of req before gnt; r/rm: cycles after the gnt cycle until rvalid (0 = same cycle).
  task automatic run_instr(input int kind, input int g, input int r, input int gm, input int rm,
                           input bit ferr, input bit merr, input bit fhang, input bit mhang,
                           input bit noise, input int hold, input string nm);
    int fc, mc, len, exp_code, exp_ireq, exp_lreq, exp_pc, exp_gpr, exp_inst;
    bit halts, in_f, in_m, fin, saw_halt;
    int cyc, n_ireq, n_lreq, n_pc, n_gpr, n_inst, n_lwe_bad, n_gpr_bad, n_hold_bad;
    int f_req_n, f_wait_n, m_req_n, m_wait_n;
    bit f_gr, f_dn, m_gr, m_dn;
    cyc = 0; n_ireq = 0; n_lreq = 0; n_pc = 0; n_gpr = 0; n_inst = 0;
    n_lwe_bad = 0; n_gpr_bad = 0; n_hold_bad = 0;
    f_req_n = 0; f_wait_n = 0; m_req_n = 0; m_wait_n = 0;
    f_gr = 0; f_dn = 0; m_gr = 0; m_dn = 0; fin = 0; saw_halt = 0;

    fc = fhang ? TMO : g + 1 + r;
    exp_ireq = fhang ? TMO : g + 1;
    exp_lreq = 0; exp_inst = 0; exp_code = 0; exp_pc = 0; exp_gpr = 0; halts = 1; mc = 0;
    if (fhang || ferr) begin
      len = fc; exp_code = 1;
    end else begin
      exp_inst = 1;
      if (kind == 4) begin
        len = fc + 1; exp_code = 3;
      end else if (kind == 3) begin
        len = fc + 1; exp_code = 0;
      end else if (kind == 0) begin
        len = fc + 2; halts = 0; exp_pc = 1; exp_gpr = 1;
      end else begin
        mc = mhang ? TMO : gm + 1 + rm;
        exp_lreq = mhang ? TMO : gm + 1;
        if (mhang || merr) begin
          len = fc + 1 + mc; exp_code = 2;
        end else begin
          len = fc + mc + 2; halts = 0; exp_pc = 1; exp_gpr = (kind == 2) ? 0 : 1;
        end
      end
    end

    while (!fin && cyc < 60) begin
      if (halt) begin
        saw_halt = 1;
        fin = 1;
      end else begin
        cyc++;
        if (ifu_req) n_ireq++;
        if (lsu_req) n_lreq++;
        if (pc_we) n_pc++;
        if (gpr_we) n_gpr++;
        if (gpr_we && !pc_we) n_gpr_bad++;
        if (lsu_we !== (lsu_req && (kind == 2))) n_lwe_bad++;
        in_f = ifu_req || (f_gr && !f_dn);
        in_m = lsu_req || (m_gr && !m_dn);
        ifu_gnt = 0; ifu_rvalid = 0; ifu_err = 0;
        lsu_gnt = 0; lsu_rvalid = 0; lsu_err = 0;
        dec_load    = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
        dec_store   = (kind == 2);
        dec_ebreak  = (kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
        dec_illegal = (kind == 4);
        if (ifu_req) begin
          if (!fhang && f_req_n == g) begin
            ifu_gnt = 1; f_gr = 1;
            if (r == 0) begin ifu_rvalid = 1; ifu_err = ferr; f_dn = 1; end
          end
          f_req_n++;
        end else if (f_gr && !f_dn) begin
          f_wait_n++;
          if (f_wait_n == r) begin ifu_rvalid = 1; ifu_err = ferr; f_dn = 1; end
        end
        if (lsu_req) begin
          if (!mhang && m_req_n == gm) begin
            lsu_gnt = 1; m_gr = 1;
            if (rm == 0) begin lsu_rvalid = 1; lsu_err = merr; m_dn = 1; end
          end
          m_req_n++;
        end else if (m_gr && !m_dn) begin
          m_wait_n++;
          if (m_wait_n == rm) begin lsu_rvalid = 1; lsu_err = merr; m_dn = 1; end
        end
        if (noise && in_f) begin
          lsu_gnt = 1'($urandom_range(0, 1)); lsu_rvalid = 1'($urandom_range(0, 1));
          lsu_err = 1'($urandom_range(0, 1));
        end
        if (noise && in_m) begin
          ifu_gnt = 1'($urandom_range(0, 1)); ifu_rvalid = 1'($urandom_range(0, 1));
          ifu_err = 1'($urandom_range(0, 1));
        end
        #1;
        if (inst_we) n_inst++;
        if (pc_we) fin = 1;
        @(negedge clk);
      end
    end
    idle_inputs();

    exp_cycle = exp_cycle + 32'(len);
    if (!halts) exp_instret = exp_instret + 32'd1;

    n_checks++;
    if (fin !== 1'b1) begin
      n_errors++; $display("FAIL %s bound: no pc_we/halt within %0d cycles", nm, cyc);
    end
    n_checks++;
    if (cyc !== len) begin
      n_errors++; $display("FAIL %s length: got %0d expected %0d", nm, cyc, len);
    end
    n_checks++;
    if (saw_halt !== halts) begin
      n_errors++; $display("FAIL %s halt: got %0d expected %0d", nm, saw_halt, halts);
    end
    n_checks++;
    if (n_ireq !== exp_ireq || n_lreq !== exp_lreq) begin
      n_errors++;
      $display("FAIL %s req cycles: got ifu=%0d lsu=%0d expected ifu=%0d lsu=%0d",
               nm, n_ireq, n_lreq, exp_ireq, exp_lreq);
    end
    n_checks++;
    if (n_pc !== exp_pc || n_gpr !== exp_gpr || n_gpr_bad !== 0) begin
      n_errors++;
      $display("FAIL %s strobes: got pc=%0d gpr=%0d stray=%0d expected pc=%0d gpr=%0d stray=0",
               nm, n_pc, n_gpr, n_gpr_bad, exp_pc, exp_gpr);
    end
    n_checks++;
    if (n_inst !== exp_inst) begin
      n_errors++; $display("FAIL %s inst_we: got %0d expected %0d", nm, n_inst, exp_inst);
    end
    n_checks++;
    if (n_lwe_bad !== 0) begin
      n_errors++; $display("FAIL %s lsu_we: got %0d bad cycles expected 0", nm, n_lwe_bad);
    end
    n_checks++;
    if (cycle_cnt !== exp_cycle || instret_cnt !== exp_instret) begin
      n_errors++;
      $display("FAIL %s counters: got cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
               nm, cycle_cnt, instret_cnt, exp_cycle, exp_instret);
    end
    if (halts) begin
      n_checks++;
      if (halt_code !== 2'(exp_code)) begin
        n_errors++; $display("FAIL %s halt_code: got %0d expected %0d", nm, halt_code, exp_code);
      end
      for (int i = 0; i < hold; i++) begin
        ifu_gnt = 1'($urandom_range(0, 1)); ifu_rvalid = 1'($urandom_range(0, 1));
        lsu_gnt = 1'($urandom_range(0, 1)); lsu_rvalid = 1'($urandom_range(0, 1));
        dec_load = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (ifu_req || lsu_req || pc_we || gpr_we || inst_we || !halt ||
            halt_code !== 2'(exp_code) || cycle_cnt !== exp_cycle || instret_cnt !== exp_instret)
          n_hold_bad++;
      end
      idle_inputs();
      n_checks++;
      if (n_hold_bad !== 0) begin
        n_errors++; $display("FAIL %s halt hold: got %0d bad cycles expected 0", nm, n_hold_bad);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ifu_req, lsu_req, lsu_we, inst_we, pc_we, gpr_we, halt, halt_code, cycle_cnt, instret_cnt} !== '0) begin
      n_errors++; $display("FAIL reset outputs: got nonzero expected all 0");
    end
    rst = 1;
    n_checks++;
    if (ifu_req !== 1'b0) begin
      n_errors++; $display("FAIL boot ifu_req: got %0b expected 0", ifu_req);
    end
    @(negedge clk);
    n_checks++;
    if (ifu_req !== 1'b1 || cycle_cnt !== 32'd0) begin
      n_errors++; $display("FAIL fetch entry: got req=%0b cycle=%0d expected req=1 cycle=0", ifu_req, cycle_cnt);
    end
    exp_cycle = 0;
    exp_instret = 0;
  endtask

  task automatic test_alu();
    run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "alu_first");
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "alu_combined");
  endtask

  task automatic test_load_store();
    run_instr(1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, "load_gnt3");
    run_instr(2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, "store");
    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "load_combined");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 1, 0, "b2b");
    end
  endtask

  task automatic test_ebreak();
    run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "pre_ebreak");
    run_instr(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 100, "ebreak");
    do_reset();
  endtask

  task automatic test_timeout();
    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 10, "fetch_timeout");
    do_reset();
    run_instr(0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, "fetch_edge_gnt");
    run_instr(1, 0, 7, 7, 0, 0, 0, 0, 0, 1, 0, "fetch_mem_edge");
    run_instr(2, 2, 1, 0, 0, 0, 0, 0, 1, 0, 10, "lsu_timeout");
    do_reset();
  endtask

  task automatic test_errors();
    run_instr(0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 10, "fetch_err");
    do_reset();
    run_instr(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 10, "fetch_err_comb");
    do_reset();
    run_instr(2, 0, 1, 1, 2, 0, 1, 0, 0, 0, 10, "lsu_err");
    do_reset();
    run_instr(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10, "illegal");
    do_reset();
    n_checks++;
    if (halt !== 1'b0 || halt_code !== 2'd0) begin
      n_errors++; $display("FAIL halt clear: got halt=%0b code=%0d expected 0 0", halt, halt_code);
    end
  endtask

  task automatic test_reset_mwait();
    int bad;
    bad = 0;
    ifu_gnt = 1; ifu_rvalid = 1; dec_load = 1;
    @(negedge clk);
    idle_inputs();
    dec_load = 1;
    @(negedge clk);
    n_checks++;
    if (lsu_req !== 1'b1) begin
      n_errors++; $display("FAIL mwait setup lsu_req: got %0b expected 1", lsu_req);
    end
    lsu_gnt = 1;
    @(negedge clk);
    idle_inputs();
    #2 rst = 0;
    #1;
    n_checks++;
    if ({ifu_req, lsu_req, lsu_we, inst_we, pc_we, gpr_we, halt, halt_code, cycle_cnt, instret_cnt} !== '0) begin
      n_errors++; $display("FAIL async reset outputs: got nonzero expected all 0");
    end
    @(negedge clk);
    lsu_rvalid = 1;
    rst = 1;
    if (ifu_req || pc_we || gpr_we) bad++;
    @(negedge clk);
    if (!ifu_req || lsu_req || pc_we || gpr_we || cycle_cnt !== 32'd0) bad++;
    lsu_rvalid = 0;
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL post reset sequence: got %0d bad cycles expected 0", bad);
    end
    exp_cycle = 0;
    exp_instret = 0;
    run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "after_reset");
  endtask

  task automatic test_random_halts();
    int sc;
    for (int i = 0; i < 12; i++) begin
      sc = $urandom_range(0, 5);
      run_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 1, 0, "rh_pre");
      case (sc)
        0: run_instr(3, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 0, 0, 1, 5, "rh_ebreak");
        1: run_instr(4, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 0, 0, 1, 5, "rh_illegal");
        2: run_instr(0, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 1, 0, 0, 0, 1, 5, "rh_ferr");
        3: run_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, "rh_fhang");
        4: run_instr($urandom_range(1, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 0, 1, 0, 0, 1, 5, "rh_merr");
        default: run_instr($urandom_range(1, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                           0, 0, 0, 0, 0, 1, 1, 5, "rh_mhang");
      endcase
      do_reset();
    end
  endtask

  initial begin
    exp_cycle = 0;
    exp_instret = 0;
    test_reset();
    test_alu();
    test_load_store();
    test_back_to_back();
    test_ebreak();
    test_timeout();
    test_errors();
    test_reset_mwait();
    test_random_halts();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
